// File: rtl/pipe_rca_pkg.sv
// Shared types and helpers for the pipelined ripple-carry adder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipe_rca_pkg;

    // Width-independent part of the per-stage transaction record. The
    // partial-sum and remaining-operand fields depend on N, so the top
    // module carries them in arrays indexed alongside this record.
    typedef struct packed {
        logic valid;  // stage holds a live transaction
        logic sub;    // transaction is a subtraction
        logic carry;  // carry out of this stage's chunk
    } stage_ctl_t;

    // Chunk width handled by one slice.
    function automatic int chunk_w(input int n, input int stages);
        return n / stages;
    endfunction

endpackage

// File: rtl/pipe_rca_if.sv
// Operand/result bus of pipe_rca: valid/ready on both sides.
// Latency: n/a (wiring only).
// Backpressure: out_ready stalls the whole pipe, reflected on in_ready.
interface pipe_rca_if #(
    parameter int N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         c_in;
    logic         sub;
    logic [N-1:0] mod_m;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         c_out;
    logic         ovf;

    modport master (
        output in_valid, a, b, c_in, sub, mod_m, out_ready,
        input  in_ready, out_valid, sum, c_out, ovf
    );

    modport slave (
        input  in_valid, a, b, c_in, sub, mod_m, out_ready,
        output in_ready, out_valid, sum, c_out, ovf
    );
endinterface

// File: rtl/pipe_rca_slice.sv
// W-bit combinational ripple-carry slice built from per-bit full adders.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the enclosing pipeline decides when to register it.
module pipe_rca_slice #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W-1:0] sum_o,
    output logic         cout_o,
    output logic         c_msb_in_o
);
    logic [W:0] c;

    // Ripple the carry bit by bit through full-adder equations.
    always_comb begin
        c     = '0;
        sum_o = '0;
        c[0]  = cin_i;
        for (int i = 0; i < W; i++) begin
            sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
            c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
        end
    end

    assign cout_o     = c[W];
    assign c_msb_in_o = c[W-1];
endmodule

// File: rtl/pipe_rca.sv
// Pipelined N-bit add/sub: STAGES ripple slices with registered carries; optional mod-reduce stage (PIPE_RCA_MOD_REDUCE_EN).
// Latency: STAGES cycles (STAGES+1 with PIPE_RCA_MOD_REDUCE_EN); throughput 1/cycle.
// Backpressure: global enable en = out_ready | ~out_valid freezes every stage; in_ready = en.
module pipe_rca
    import pipe_rca_pkg::*;
#(
    parameter int N      = 32,
    parameter int STAGES = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    pipe_rca_if.slave bus
);
    localparam int W = chunk_w(N, STAGES);

    if ((N % STAGES) != 0) begin : g_bad_cfg
        $error("pipe_rca: N must be divisible by STAGES");
    end

    logic         en;
    logic         out_vld;
    logic [N-1:0] b_eff;

    stage_ctl_t   ctl_q  [STAGES];
    stage_ctl_t   ctl_d  [STAGES];
    logic [N-1:0] psum_q [STAGES];
    logic [N-1:0] psum_d [STAGES];
    logic [N-1:0] a_q    [STAGES];
    logic [N-1:0] a_d    [STAGES];
    logic [N-1:0] b_q    [STAGES];
    logic [N-1:0] b_d    [STAGES];
    logic [W-1:0] sl_a   [STAGES];
    logic [W-1:0] sl_b   [STAGES];
    logic [W-1:0] sl_sum [STAGES];
    logic         sl_cin [STAGES];
    logic         sl_cout[STAGES];
    logic         sl_cmsb[STAGES];
    logic         ovf_q, ovf_d;

    assign en           = bus.out_ready | ~out_vld;
    assign bus.in_ready = en;
    assign bus.out_valid = out_vld;

    // Subtraction is A + ~B + 1: invert B once at the input and force carry-in.
    assign b_eff = bus.sub ? ~bus.b : bus.b;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign sl_a[k]   = bus.a[W-1:0];
            assign sl_b[k]   = b_eff[W-1:0];
            assign sl_cin[k] = bus.sub | bus.c_in;
            assign a_d[k]    = bus.a >> W;
            assign b_d[k]    = b_eff >> W;
            assign psum_d[k] = N'(sl_sum[k]);
            assign ctl_d[k]  = '{valid: bus.in_valid, sub: bus.sub, carry: sl_cout[k]};
        end else begin : g_next
            // Unconsumed operand bits sit right-aligned; lower sum chunks ride along.
            assign sl_a[k]   = a_q[k-1][W-1:0];
            assign sl_b[k]   = b_q[k-1][W-1:0];
            assign sl_cin[k] = ctl_q[k-1].carry;
            assign a_d[k]    = a_q[k-1] >> W;
            assign b_d[k]    = b_q[k-1] >> W;
            assign psum_d[k] = psum_q[k-1] | (N'(sl_sum[k]) << (k * W));
            assign ctl_d[k]  = '{valid: ctl_q[k-1].valid, sub: ctl_q[k-1].sub,
                                 carry: sl_cout[k]};
        end

        pipe_rca_slice #(.W(W)) u_slice (
            .a_i        (sl_a[k]),
            .b_i        (sl_b[k]),
            .cin_i      (sl_cin[k]),
            .sum_o      (sl_sum[k]),
            .cout_o     (sl_cout[k]),
            .c_msb_in_o (sl_cmsb[k])
        );
    end

    // Signed overflow: carry into the MSB differs from carry out of it.
    assign ovf_d = sl_cout[STAGES-1] ^ sl_cmsb[STAGES-1];

    // Advance every stage together whenever the output is free to move.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                ctl_q[k]  <= '0;
                psum_q[k] <= '0;
                a_q[k]    <= '0;
                b_q[k]    <= '0;
            end
            ovf_q <= 1'b0;
        end else if (en) begin
            for (int k = 0; k < STAGES; k++) begin
                ctl_q[k]  <= ctl_d[k];
                psum_q[k] <= psum_d[k];
                a_q[k]    <= a_d[k];
                b_q[k]    <= b_d[k];
            end
            ovf_q <= ovf_d;
        end
    end

`ifdef PIPE_RCA_MOD_REDUCE_EN
    logic [N-1:0] m_q [STAGES];
    logic [N:0]   full_res;
    logic [N-1:0] red_d;
    logic         rvld_q, rcout_q, rovf_q;
    logic [N-1:0] rsum_q;

    // Pick the corrected result: fold an add back below m, or undo a borrow.
    always_comb begin
        full_res = {ctl_q[STAGES-1].carry, psum_q[STAGES-1]};
        red_d    = psum_q[STAGES-1];
        if (ctl_q[STAGES-1].sub) begin
            if (!ctl_q[STAGES-1].carry) begin
                red_d = psum_q[STAGES-1] + m_q[STAGES-1];
            end
        end else if (full_res >= {1'b0, m_q[STAGES-1]}) begin
            red_d = psum_q[STAGES-1] - m_q[STAGES-1];
        end
    end

    // Modulus travels with its transaction; extra stage registers the reduced result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                m_q[k] <= '0;
            end
            rvld_q  <= 1'b0;
            rsum_q  <= '0;
            rcout_q <= 1'b0;
            rovf_q  <= 1'b0;
        end else if (en) begin
            m_q[0] <= bus.mod_m;
            for (int k = 1; k < STAGES; k++) begin
                m_q[k] <= m_q[k-1];
            end
            rvld_q  <= ctl_q[STAGES-1].valid;
            rsum_q  <= red_d;
            rcout_q <= ctl_q[STAGES-1].carry;
            rovf_q  <= ovf_q;
        end
    end

    assign out_vld   = rvld_q;
    assign bus.sum   = rsum_q;
    assign bus.c_out = rcout_q;
    assign bus.ovf   = rovf_q;
`else
    logic unused_mod_m;
    assign unused_mod_m = ^bus.mod_m;

    assign out_vld   = ctl_q[STAGES-1].valid;
    assign bus.sum   = psum_q[STAGES-1];
    assign bus.c_out = ctl_q[STAGES-1].carry;
    assign bus.ovf   = ovf_q;
`endif

endmodule
